// File: rtl/cache_refill_pkg.sv
// cache_refill_pkg
// Shared definitions for the cache refill engine: default geometry,
// refill FSM state encoding, the fixed burst-length field width, and
// helpers that derive beat count / offset / counter widths from a geometry.
package cache_refill_pkg;

  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_BEAT_WIDTH  = 32;
  localparam int DEF_INDEX_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH  = 32;

  // Width of the mem_req_len field (beats minus one).
  localparam int LEN_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    WRITE,
    DONE
  } state_t;

  // Number of memory beats per cache line.
  function automatic int beats_of(input int line_width, input int beat_width);
    return line_width / beat_width;
  endfunction

  // Number of byte-offset bits inside one line.
  function automatic int offset_width_of(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  // Beat counter width, never below one bit.
  function automatic int cnt_width_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS        = beats_of(DEF_LINE_WIDTH, DEF_BEAT_WIDTH);
  localparam int OFFSET_WIDTH = offset_width_of(DEF_LINE_WIDTH);

endpackage

// File: rtl/cache_refill_if.sv
// cache_refill_if
// Bundles every handshake/bus signal of the refill engine:
//   miss_*      : refill request from the cache miss logic
//   mem_req_*   : burst read request to memory
//   mem_r*      : burst read data beats from memory
//   da_*        : data array write port
//   refill_*    : completion pulse and framing error flag
// Modports:
//   master : the refill engine itself
//   slave  : its environment (miss logic, memory, data array)
interface cache_refill_if #(
  parameter int LINE_WIDTH  = cache_refill_pkg::DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH  = cache_refill_pkg::DEF_BEAT_WIDTH,
  parameter int INDEX_WIDTH = cache_refill_pkg::DEF_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = cache_refill_pkg::DEF_ADDR_WIDTH
);

  logic                                 miss_valid;
  logic                                 miss_ready;
  logic [ADDR_WIDTH-1:0]                miss_addr;
  logic [INDEX_WIDTH-1:0]               miss_index;

  logic                                 mem_req_valid;
  logic                                 mem_req_ready;
  logic [ADDR_WIDTH-1:0]                mem_req_addr;
  logic [cache_refill_pkg::LEN_WIDTH-1:0] mem_req_len;

  logic                                 mem_rvalid;
  logic                                 mem_rready;
  logic [BEAT_WIDTH-1:0]                mem_rdata;
  logic                                 mem_rlast;

  logic                                 da_wen;
  logic [INDEX_WIDTH-1:0]               da_waddr;
  logic [LINE_WIDTH-1:0]                da_wdata;

  logic                                 refill_done;
  logic                                 refill_err;

  modport master (
    input  miss_valid, miss_addr, miss_index,
    output miss_ready,
    output mem_req_valid, mem_req_addr, mem_req_len,
    input  mem_req_ready,
    input  mem_rvalid, mem_rdata, mem_rlast,
    output mem_rready,
    output da_wen, da_waddr, da_wdata,
    output refill_done, refill_err
  );

  modport slave (
    output miss_valid, miss_addr, miss_index,
    input  miss_ready,
    input  mem_req_valid, mem_req_addr, mem_req_len,
    output mem_req_ready,
    output mem_rvalid, mem_rdata, mem_rlast,
    input  mem_rready,
    input  da_wen, da_waddr, da_wdata,
    input  refill_done, refill_err
  );

endinterface

// File: rtl/cache_refill_linebuf.sv
// cache_refill_linebuf
// Line assembly buffer: one BEAT_WIDTH register per beat slot plus the beat
// counter that selects which slot the next accepted beat lands in.
// Ports:
//   i_clk, i_resetn : clock, asynchronous active-low reset
//   i_clear         : restart counting at beat 0 (new refill)
//   i_beat_we       : accepted beat this cycle
//   i_beat_data     : beat payload
//   o_cnt           : current beat slot
//   o_last_beat     : current slot is the final one of the line
//   o_line          : assembled line (slot 0 in the low bits)
module cache_refill_linebuf #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = 8,
  parameter int CNT_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_clear,
  input  logic                  i_beat_we,
  input  logic [BEAT_WIDTH-1:0] i_beat_data,
  output logic [CNT_W-1:0]      o_cnt,
  output logic                  o_last_beat,
  output logic [LINE_WIDTH-1:0] o_line
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wraps to 0 after the last slot; the FSM, not the wrap, ends the burst.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat_we) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [BEAT_WIDTH-1:0] r_beat;

      always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          r_beat <= '0;
        end else if (i_beat_we && (r_cnt == CNT_W'(gi))) begin
          r_beat <= i_beat_data;
        end
      end

      assign o_line[gi*BEAT_WIDTH +: BEAT_WIDTH] = r_beat;
    end
  endgenerate

  assign o_cnt       = r_cnt;
  assign o_last_beat = (r_cnt == LAST_CNT);

endmodule

// File: rtl/cache_refill.sv
// cache_refill
// Cache refill engine: accepts a miss, issues one line-aligned burst read,
// gathers the beats into a line and writes it to the data array in a single
// cycle, then pulses refill_done (with refill_err on bad burst framing).
// Ports:
//   i_clk    : clock
//   i_resetn : asynchronous active-low reset
//   bus      : cache_refill_if.master (miss, memory, data array, status)
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic           i_clk,
  input  logic           i_resetn,
  cache_refill_if.master bus
);

  localparam int NBEATS = beats_of(LINE_WIDTH, BEAT_WIDTH);
  localparam int OFF_W  = offset_width_of(LINE_WIDTH);
  localparam int CNT_W  = cnt_width_of(NBEATS);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [LEN_WIDTH-1:0]  REQ_LEN     = LEN_WIDTH'(NBEATS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT    = CNT_W'(NBEATS - 1);

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_err;
  logic                   r_miss_ready;
  logic                   r_mem_req_valid;
  logic                   r_mem_rready;
  logic                   r_da_wen;
  logic                   r_refill_done;
  logic                   r_refill_err;

  logic                   w_miss_fire;
  logic                   w_beat_fire;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_last_beat;
  logic [LINE_WIDTH-1:0]  w_line;

  // miss_ready / mem_rready are registered and high exactly in IDLE / RECV,
  // so the state test alone completes each handshake.
  assign w_miss_fire = (r_state == IDLE) && bus.miss_valid;
  assign w_beat_fire = (r_state == RECV) && bus.mem_rvalid;

  cache_refill_linebuf #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (NBEATS),
    .CNT_W      (CNT_W)
  ) u_linebuf (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_clear     (w_miss_fire),
    .i_beat_we   (w_beat_fire),
    .i_beat_data (bus.mem_rdata),
    .o_cnt       (w_cnt),
    .o_last_beat (w_last_beat),
    .o_line      (w_line)
  );

  // Outputs are registered alongside the state: each transition loads the
  // output values of the state being entered.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_index         <= '0;
      r_err           <= 1'b0;
      r_miss_ready    <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_rready    <= 1'b0;
      r_da_wen        <= 1'b0;
      r_refill_done   <= 1'b0;
      r_refill_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.miss_valid) begin
            r_addr          <= bus.miss_addr & ~OFFSET_MASK;
            r_index         <= bus.miss_index;
            r_err           <= 1'b0;
            r_miss_ready    <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_rready    <= 1'b1;
            r_state         <= RECV;
          end
        end
        RECV: begin
          if (bus.mem_rvalid) begin
            if (bus.mem_rlast && (w_cnt != LAST_CNT)) begin
              // Burst ended early: drop the partial line.
              r_err         <= 1'b1;
              r_mem_rready  <= 1'b0;
              r_refill_done <= 1'b1;
              r_refill_err  <= 1'b1;
              r_state       <= DONE;
            end else if (w_last_beat) begin
              r_mem_rready <= 1'b0;
              if (bus.mem_rlast) begin
                r_da_wen <= 1'b1;
                r_state  <= WRITE;
              end else begin
                // Final slot filled but memory did not mark it last.
                r_err         <= 1'b1;
                r_refill_done <= 1'b1;
                r_refill_err  <= 1'b1;
                r_state       <= DONE;
              end
            end
          end
        end
        WRITE: begin
          r_da_wen      <= 1'b0;
          r_refill_done <= 1'b1;
          r_refill_err  <= r_err;
          r_state       <= DONE;
        end
        DONE: begin
          r_refill_done <= 1'b0;
          r_refill_err  <= 1'b0;
          r_miss_ready  <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_state         <= IDLE;
          r_miss_ready    <= 1'b1;
          r_mem_req_valid <= 1'b0;
          r_mem_rready    <= 1'b0;
          r_da_wen        <= 1'b0;
          r_refill_done   <= 1'b0;
          r_refill_err    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.miss_ready    = r_miss_ready;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_req_valid ? r_addr : '0;
  assign bus.mem_req_len   = r_mem_req_valid ? REQ_LEN : '0;
  assign bus.mem_rready    = r_mem_rready;
  assign bus.da_wen        = r_da_wen;
  assign bus.da_waddr      = r_index;
  assign bus.da_wdata      = w_line;
  assign bus.refill_done   = r_refill_done;
  assign bus.refill_err    = r_refill_err;

endmodule
